// File: rtl/mul_cdb_buffer.sv
// mul_cdb_buffer: multiplier result FIFO that drains onto a CDB port via req/grant and hands out issue credits
//  clock_i/reset_i            clock, synchronous active-high reset
//  mul_enable_i               multiply issued this cycle (takes a credit)
//  mul_valid_i + mul_*_i      multiplier result push
//  cdb_grant_i                arbiter grant, pops the head when cdb_req_o=1
//  cdb_req_o + cdb_*_o        head entry broadcast (all zero when empty)
//  mul_issue_ok_o             one more multiply fits in buffer + pipeline
//  overflow_err_o             sticky: a result was dropped on a full FIFO
module mul_cdb_buffer #(
  parameter int XLEN    = 32,
  parameter int PRF_LEN = 6,
  parameter int ROB_LEN = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               mul_enable_i,
  input  logic               mul_valid_i,
  input  logic [XLEN-1:0]    mul_value_i,
  input  logic [PRF_LEN-1:0] mul_prf_idx_i,
  input  logic [ROB_LEN-1:0] mul_rob_idx_i,
  input  logic [XLEN-1:0]    mul_PC_i,
  input  logic               cdb_grant_i,
  output logic               cdb_req_o,
  output logic [XLEN-1:0]    cdb_value_o,
  output logic [PRF_LEN-1:0] cdb_prf_idx_o,
  output logic [ROB_LEN-1:0] cdb_rob_idx_o,
  output logic [XLEN-1:0]    cdb_PC_o,
  output logic               mul_issue_ok_o,
  output logic               overflow_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * XLEN + PRF_LEN + ROB_LEN;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
  logic          overflow_q, overflow_d, full, pop, wr;
  logic [EW-1:0] head_ent;
  assign cdb_req_o = count_q != '0;
  // A pop frees the head slot on the same edge, so a full FIFO still accepts a push alongside it.
  always_comb begin
    full       = count_q == CW'(DEPTH);
    pop        = cdb_req_o & cdb_grant_i;
    wr         = mul_valid_i & (~full | pop);
    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + PW'(wr);
    count_d    = count_q + CW'(wr) - CW'(pop);
    inflight_d = (mul_enable_i & ~mul_valid_i) ? inflight_q + CW'(1) :
                 (mul_valid_i & ~mul_enable_i & (inflight_q != '0)) ? inflight_q - CW'(1) :
                 inflight_q;
    overflow_d = overflow_q | (mul_valid_i & ~wr);
    head_ent   = cdb_req_o ? mem_q[head_q] : '0;
  end
  assign {cdb_value_o, cdb_prf_idx_o, cdb_rob_idx_o, cdb_PC_o} = head_ent;
  // Extra bit so a protocol-violating sum above DEPTH cannot wrap back under it.
  assign mul_issue_ok_o = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);
  assign overflow_err_o = overflow_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (wr) mem_q[tail_q] <= {mul_value_i, mul_prf_idx_i, mul_rob_idx_i, mul_PC_i};
  end
endmodule
